alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Parametrised ALU with built-in operation decode for the multi-cycle datapath.
//   Accepts the ALUop/one-hot function pair from the main controller and executes the op.
//   Single-cycle ops: AOUT/BOUT/ADD/SUB/AND/OR/NOTB. Iterative ops: SHL and MUL.
//   A start/busy/done handshake lets the controller FSM stall on iterative ops.
// PARAMETERS
//   WIDTH   16  operand and result width in bits (>=4)
//   MUL_EN  1   1: MUL supported; 0: MUL function reported as illegal (err)
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      synchronous reset, active low
//   start         in   1      request; sampled only in IDLE
//   alu_op        in   3      100 ADD, 101 SUB, 110 AND, 111 OR (force); 000 decode alu_function
//   alu_function  in   9      one-hot: b0 AOUT, b1 BOUT, b2 ADD, b3 SUB, b4 AND, b5 OR, b6 NOTB, b7 SHL, b8 MUL
//   a, b          in   WIDTH  operands; SHL amount = b[$clog2(WIDTH)-1:0]
//   result        out  WIDTH  registered result, held until next completion
//   zero          out  1      result==0, updated with result
//   carry         out  1      ADD: carry-out; SUB: 1 when a>=b unsigned (no borrow); else 0
//   err           out  1      illegal op on last completion
//   busy          out  1      iterative op in progress
//   done          out  1      one-cycle pulse on every completion (legal or illegal)
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state IDLE. result=0, zero=0, carry=0, err=0, busy=0, done=0.
//     Reset mid-op aborts the op; no done pulse is produced.
//   States: IDLE, SHIFT, MUL.
//     IDLE->SHIFT: start with SHL and amount>0.
//     IDLE->MUL: start with MUL and MUL_EN=1.
//     SHIFT/MUL->IDLE: on the final iteration edge.
//   Op select:
//     alu_op 1xx forces its op and ignores alu_function.
//     alu_op 000 decodes alu_function; it must be exactly one-hot.
//     alu_op 001/010/011, a non-one-hot function, or MUL with MUL_EN=0 is illegal.
//   Illegal op at start edge k: result=0, zero=0, carry=0, err=1, done=1 during cycle k+1.
//   Single-cycle op or SHL amount 0 (start edge k):
//     result/flags registered at edge k; done=1 for one cycle after edge k; busy stays 0.
//   Arithmetic:
//     ADD = a+b mod 2^WIDTH. SUB = a+~b+1 mod 2^WIDTH.
//     NOTB = ~b. AOUT = a. BOUT = b.
//   Iterative op (start edge k):
//     a, b and amount latched at edge k; busy=1 from edge k.
//     Later input changes have no effect.
//   SHL amount s: one bit per edge; final edge k+s writes result=a<<s (low WIDTH bits).
//   MUL: shift-add, one multiplier bit per edge; final edge k+WIDTH writes low WIDTH bits of a*b.
//   Final iteration edge: busy->0, done=1 for one cycle, err=0, carry=0, zero updated.
//   start while busy: ignored, not queued. start at the same edge busy falls: ignored.
//   err is cleared by the next legal completion.
//   result and flags change only at completion edges.
// TESTING (WIDTH=16, MUL_EN=1)
//   1. ADD via fn=0x004, a=0x7FFF, b=0x0001 -> result=0x8000, carry=0, zero=0; done 1 cycle after start; busy never 1.
//   2. alu_op=101, fn=0x010 (ignored): a=3, b=5 -> 0xFFFE, carry=0. Then a=5, b=5 -> 0x0000, zero=1, carry=1.
//   3. MUL fn=0x100, a=0x0012, b=0x0034 -> result=0x03A8 at edge k+16; busy high 16 cycles. start with ADD at k+4 ignored.
//   4. SHL fn=0x080: a=0x0001, b=0x0005 -> 0x0020 at edge k+5. b=0x0010 (amount 0) -> 0x0001 single-cycle.
//   5. fn=0x00C -> err=1, result=0, done pulse. alu_op=010 -> err=1. Then a legal ADD -> err=0.
//   6. rst_n=0 at MUL iteration 7 -> next edge busy=0, done=0, result=0. Fresh ADD afterwards completes normally.

Source files
------------

// File: rtl/alu_seq_unit.sv
// ALU with op decode: single-cycle ops finish at the start edge, SHL takes one edge per bit, MUL one edge per multiplier bit.
// Latency 1 cycle (single-cycle/illegal), s (SHL), WIDTH (MUL); start is dropped, not queued, while busy.
module alu_seq_unit #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [8:0]       alu_function,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL
  } state_t;

  typedef enum logic [3:0] {
    OP_AOUT,
    OP_BOUT,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_NOTB,
    OP_SHL,
    OP_MUL,
    OP_ILL
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [SW-1:0]    amt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH-1:0] shl_nxt;
  logic [WIDTH-1:0] mul_nxt;

  assign amt = b[SW-1:0];

  // A forced alu_op wins; otherwise the function must match exactly one one-hot code.
  always_comb begin
    op = OP_ILL;
    if (alu_op[2]) begin
      case (alu_op[1:0])
        2'b00:   op = OP_ADD;
        2'b01:   op = OP_SUB;
        2'b10:   op = OP_AND;
        default: op = OP_OR;
      endcase
    end else if (alu_op == 3'b000) begin
      case (alu_function)
        9'h001:  op = OP_AOUT;
        9'h002:  op = OP_BOUT;
        9'h004:  op = OP_ADD;
        9'h008:  op = OP_SUB;
        9'h010:  op = OP_AND;
        9'h020:  op = OP_OR;
        9'h040:  op = OP_NOTB;
        9'h080:  op = OP_SHL;
        9'h100:  op = MUL_EN ? OP_MUL : OP_ILL;
        default: op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    dif_ext  = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op)
      OP_AOUT: sc_res = a;
      OP_BOUT: sc_res = b;
      OP_ADD: begin
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        // Carry-out of a + ~b + 1 is the no-borrow flag (a >= b unsigned).
        sc_res   = dif_ext[WIDTH-1:0];
        sc_carry = dif_ext[WIDTH];
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOTB: sc_res = ~b;
      default: sc_res = '0;
    endcase
  end

  assign shl_nxt = {acc[WIDTH-2:0], 1'b0};
  assign mul_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_ILL: begin
                result <= '0;
                zero   <= 1'b0;
                carry  <= 1'b0;
                err    <= 1'b1;
                done   <= 1'b1;
              end
              OP_SHL: begin
                if (amt == '0) begin
                  result <= a;
                  zero   <= (a == '0);
                  carry  <= 1'b0;
                  err    <= 1'b0;
                  done   <= 1'b1;
                end else begin
                  state <= S_SHIFT;
                  busy  <= 1'b1;
                  acc   <= a;
                  cnt   <= CW'(amt);
                end
              end
              OP_MUL: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= CW'(WIDTH);
              end
              default: begin
                result <= sc_res;
                zero   <= (sc_res == '0);
                carry  <= sc_carry;
                err    <= 1'b0;
                done   <= 1'b1;
              end
            endcase
          end
        end

        S_SHIFT: begin
          acc <= shl_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            result <= shl_nxt;
            zero   <= (shl_nxt == '0);
            carry  <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b1;
          end
        end

        S_MUL: begin
          // Shift-add: one multiplier bit consumed per edge, LSB first.
          acc    <= mul_nxt;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            result <= mul_nxt;
            zero   <= (mul_nxt == '0);
            carry  <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: stimulus pushes expected completions, a negedge monitor pops them on done.
module tb_alu_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  alu_op;
  logic [8:0]  alu_function;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        err;
  logic        busy;
  logic        done;

  alu_seq_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .alu_op       (alu_op),
    .alu_function (alu_function),
    .a            (a),
    .b            (b),
    .result       (result),
    .zero         (zero),
    .carry        (carry),
    .err          (err),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [15:0] r;
    logic        z;
    logic        c;
    logic        e;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_checks = 0;
  int   n_err    = 0;
  int   edge_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Done is sampled on the falling edge; edge_cnt then names the edge that produced it.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no completion", result);
      end else begin
        me = q.pop_front();
        chk("result", result, me.r);
        chk("zero", zero, me.z);
        chk("carry", carry, me.c);
        chk("err", err, me.e);
        chk("done_edge", edge_cnt, me.t);
      end
    end
  end

  // Start is presented for exactly one edge (edge k); lat is the edge count from k to completion.
  task automatic issue(input logic [2:0] op, input logic [8:0] fn, input logic [15:0] aa,
                       input logic [15:0] bb, input logic [15:0] r, input logic z,
                       input logic c, input logic e, input int lat, input bit push);
    exp_t x;
    @(negedge clk);
    alu_op = op; alu_function = fn; a = aa; b = bb; start = 1'b1;
    if (push) begin
      x.r = r; x.z = z; x.c = c; x.e = e; x.t = edge_cnt + 1 + lat;
      q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    rst_n = 1'b0; start = 1'b0; alu_op = 3'b000; alu_function = 9'h000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", zero, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;

    // Single-cycle ops
    issue(3'b000, 9'h004, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("add_busy", busy, 1'b0);
    issue(3'b000, 9'h004, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    issue(3'b101, 9'h010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b101, 9'h010, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    issue(3'b110, 9'h000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b111, 9'h000, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b000, 9'h040, 16'h1111, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b000, 9'h001, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b000, 9'h002, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    issue(3'b000, 9'h008, 16'h0010, 16'h0003, 16'h000D, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    drain();

    // MUL with an ignored start while busy and one at the edge busy falls
    issue(3'b000, 9'h100, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 16, 1'b1);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      else break;
      if (i == 3 || i == 15) begin
        alu_op = 3'b100; alu_function = 9'h000; a = 16'h0001; b = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", nb, 16);
    drain();
    repeat (3) @(negedge clk);
    issue(3'b000, 9'h100, 16'h1234, 16'h0100, 16'h3400, 1'b0, 1'b0, 1'b0, 16, 1'b1);
    drain();
    issue(3'b000, 9'h100, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16, 1'b1);
    drain();

    // SHL
    issue(3'b000, 9'h080, 16'h0001, 16'h0005, 16'h0020, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    chk("shl_busy", busy, 1'b1);
    drain();
    issue(3'b000, 9'h080, 16'h0001, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("shl0_busy", busy, 1'b0);
    issue(3'b000, 9'h080, 16'h8001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 15, 1'b1);
    drain();
    issue(3'b000, 9'h080, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    drain();

    // Illegal ops, then a legal op clears err
    issue(3'b000, 9'h00C, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    issue(3'b010, 9'h004, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    issue(3'b000, 9'h000, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    issue(3'b000, 9'h004, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    drain();

    // Reset in the middle of a MUL: no completion, outputs cleared
    issue(3'b000, 9'h100, 16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 16, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_result", result, 16'h0000);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(3'b000, 9'h004, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
